// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and default geometry for serial_adder_n.
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIGIT = 1;

endpackage

`default_nettype wire

// File: rtl/fa_digit.sv
// fa_digit: DIGIT-bit ripple of full-adder cells; cmsb is the carry into the top bit.
`default_nettype none

module fa_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  always_comb begin : ripple
    logic c;
    sum  = '0;
    c    = ci;
    cmsb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      cmsb   = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial adder, DIGIT bits per cycle, registered result.
// Optional macro SERIAL_ADDER_SUB_EN enables subtraction through the sub port.
`default_nettype none

module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dcmsb;

  logic [WIDTH-1:0] cap_b;
  logic             cap_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign cap_b = sub ? ~b : b;
  assign cap_c = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign cap_b      = b;
  assign cap_c      = cin;
`endif

  fa_digit #(
    .DIGIT (DIGIT)
  ) u_fa_digit (
    .x    (opa[DIGIT-1:0]),
    .y    (opb[DIGIT-1:0]),
    .ci   (carry),
    .sum  (dsum),
    .co   (dco),
    .cmsb (dcmsb)
  );

  // New digits enter at the MSB end so the sum is aligned after the last digit.
  if (DIGIT == WIDTH) begin : g_acc_full
    assign acc_next = dsum;
  end else begin : g_acc_shift
    assign acc_next = {dsum, acc[WIDTH-1:DIGIT]};
  end

  assign last = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= cap_b;
            carry <= cap_c;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          acc   <= acc_next;
          carry <= dco;
          cnt   <= cnt + 1'b1;
          if (last) begin
            s     <= acc_next;
            cout  <= dco;
            ovf   <= dco ^ dcmsb;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: checks DIGIT=1 and DIGIT=2 instances against an arithmetic model.
`default_nettype none

module tb_serial_adder_n;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cin   = 1'b0;
  logic       sub   = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] s1;
  logic       busy2, done2, cout2, ovf2;
  logic [7:0] s2;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder_n #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no_done required=done_within_budget", name);
  endtask

  // Model: result is plain a+b+cin, ready NDIG+1 cycles after the start cycle.
  function automatic int ncyc(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  bit         m_busy [2];
  bit         m_done [2];
  bit         m_cout [2];
  bit         m_ovf  [2];
  logic [7:0] m_s    [2];
  int         m_left [2];
  logic [8:0] p_sum  [2];
  bit         p_ovf  [2];

  always @(posedge clk) begin : model
    logic [7:0] bb;
    logic       c0;
    logic [8:0] t;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cout[i] = 1'b0;
        m_ovf[i]  = 1'b0; m_s[i]    = 8'h00; m_left[i] = 0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_s[i]    = p_sum[i][7:0];
            m_cout[i] = p_sum[i][8];
            m_ovf[i]  = p_ovf[i];
          end
        end else if (start) begin
          bb = b;
          c0 = cin;
`ifdef SERIAL_ADDER_SUB_EN
          if (sub) begin
            bb = ~b;
            c0 = 1'b1;
          end
`endif
          t         = {1'b0, a} + {1'b0, bb} + {8'h00, c0};
          p_sum[i]  = t;
          p_ovf[i]  = (a[7] == bb[7]) && (t[7] != a[7]);
          m_busy[i] = 1'b1;
          m_left[i] = ncyc(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy1", 64'(busy1), 64'(m_busy[0]));
      chk("done1", 64'(done1), 64'(m_done[0]));
      chk("s1",    64'(s1),    64'(m_s[0]));
      chk("cout1", 64'(cout1), 64'(m_cout[0]));
      chk("ovf1",  64'(ovf1),  64'(m_ovf[0]));
      chk("busy2", 64'(busy2), 64'(m_busy[1]));
      chk("done2", 64'(done2), 64'(m_done[1]));
      chk("s2",    64'(s2),    64'(m_s[1]));
      chk("cout2", 64'(cout2), 64'(m_cout[1]));
      chk("ovf2",  64'(ovf2),  64'(m_ovf[1]));
    end
  end

  // One start pulse; optionally a second start while busy with other operands.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input bit mid,
                        output int l1, output int l2, output int nd1);
    l1 = 0; l2 = 0; nd1 = 0;
    @(posedge clk); #2;
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    for (int k = 1; k <= 40 && (l1 == 0 || l2 == 0); k++) begin
      @(posedge clk); #2;
      start = mid && (k == 3);
      if (mid && k == 3) begin
        a = 8'hAA;
        b = 8'h55;
      end
      @(negedge clk);
      if (done1) begin
        nd1++;
        if (l1 == 0) l1 = k;
      end
      if (done2 && l2 == 0) l2 = k;
    end
    if (l1 == 0) timeout("run_op_dut1");
    if (l2 == 0) timeout("run_op_dut2");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done1) nd1++;
    end
  endtask

  initial begin : main
    int l1, l2, nd1, nd2, lat;
    bit seen;

    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_s1",    64'(s1),    64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, l1, l2, nd1);
    chk("ff01_lat1", 64'(l1), 64'd9);
    chk("ff01_s1",   64'(s1), 64'h00);
    chk("ff01_cout1", 64'(cout1), 64'd1);
    chk("ff01_ovf1",  64'(ovf1),  64'd0);
    chk("ff01_lat2", 64'(l2), 64'd5);

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, l1, l2, nd1);
    chk("7f01_lat2",  64'(l2),    64'd5);
    chk("7f01_s2",    64'(s2),    64'h80);
    chk("7f01_cout2", 64'(cout2), 64'd0);
    chk("7f01_ovf2",  64'(ovf2),  64'd1);

    run_op(8'h35, 8'h0A, 1'b1, 1'b0, 1'b1, l1, l2, nd1);
    chk("mid_s1",     64'(s1),  64'h40);
    chk("mid_s2",     64'(s2),  64'h40);
    chk("mid_ndone1", 64'(nd1), 64'd1);

    @(posedge clk); #2;
    a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy1", 64'(busy1), 64'd0);
    chk("abort_done1", 64'(done1), 64'd0);
    chk("abort_s1",    64'(s1),    64'd0);
    chk("abort_cout1", 64'(cout1), 64'd0);
    chk("abort_ovf1",  64'(ovf1),  64'd0);
    chk("abort_busy2", 64'(busy2), 64'd0);
    chk("abort_s2",    64'(s2),    64'd0);
    nd1 = 0; nd2 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done1) nd1++;
      if (done2) nd2++;
    end
    chk("abort_nodone1", 64'(nd1), 64'd0);
    chk("abort_nodone2", 64'(nd2), 64'd0);
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, l1, l2, nd1);
    chk("after_rst_s1", 64'(s1), 64'h4B);
    chk("after_rst_s2", 64'(s2), 64'h4B);

    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, l1, l2, nd1);
`ifdef SERIAL_ADDER_SUB_EN
    chk("sub_s1",    64'(s1),    64'hFE);
    chk("sub_cout1", 64'(cout1), 64'd0);
`else
    chk("nosub_s1",    64'(s1),    64'h0C);
    chk("nosub_cout1", 64'(cout1), 64'd0);
`endif

    @(posedge clk); #2;
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    if (!seen) timeout("b2b_first");
    chk("b2b_s1_first", 64'(s1), 64'h46);
    #1;
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #2 start = 1'b0;
      @(negedge clk);
      if (k == 1) chk("b2b_busy_no_idle", 64'(busy1), 64'd1);
      if (done1) lat = k;
    end
    if (lat == 0) timeout("b2b_second");
    chk("b2b_lat",   64'(lat),   64'd9);
    chk("b2b_s1",    64'(s1),    64'h01);
    chk("b2b_cout1", 64'(cout1), 64'd1);
    chk("b2b_ovf1",  64'(ovf1),  64'd1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
